flood_engine: RTL and testbench
===============================

# flood_engine

Parametrised board-state and flood-fill engine for the Flood-It design. It generalises the fixed 26x26, 8-colour game logic to any board up to MAX_SIZE x MAX_SIZE with configurable colour depth. It adds a move limit, win/loss detection, rejection of illegal moves and a registered read port for the VGA renderer. It sits between the selector (moves, new-game requests), the board generator (cell loading) and displayVGA (cell reads).

## Interface
- MAX_SIZE, 26: largest board edge; cell address = row*MAX_SIZE + col.
- COLOR_BITS, 3: bits per cell colour.
- ADDR_BITS, 10: cell address width; must satisfy 2^ADDR_BITS >= MAX_SIZE^2.
- MOVE_BITS, 8: move counter width.

- CLOCK  in  1  engine clock.
- RESET  in  1  asynchronous, active-high reset.
- SIZE  in  5  active board edge N, sampled on NEW_GAME; clamped to 2..MAX_SIZE.
- COLOR_NUM  in  4  colours in play, sampled on NEW_GAME.
- MOVE_LIMIT  in  MOVE_BITS  sampled on NEW_GAME; 0 = unlimited.
- LOAD_EN  in  1  write LOAD_COLOR to LOAD_ADDR this cycle.
- LOAD_ADDR  in  ADDR_BITS  load address.
- LOAD_COLOR  in  COLOR_BITS  load data.
- NEW_GAME  in  1  single-cycle strobe; starts a game on the loaded board.
- COLOR_SEL_SIG  in  1  single-cycle move strobe.
- COLOR_SELECTED  in  COLOR_BITS  colour for the move.
- RD_ADDR  in  ADDR_BITS  display read address.
- RD_COLOR  out  COLOR_BITS  colour at RD_ADDR, registered.
- BUSY  out  1  engine is processing.
- MOVE_DONE  out  1  one-cycle pulse when a move or initial flood completes.
- REJECTED  out  1  one-cycle pulse when a move is refused.
- MOVES  out  MOVE_BITS  accepted moves, saturating.
- WON  out  1  whole board is owned.
- LOST  out  1  move limit reached without a win.

## Operation
- State: cell colour RAM (MAX_SIZE^2 x COLOR_BITS), owned mask (MAX_SIZE^2 bits), CUR colour, owned counter, row/col scan counters.
- FSM states: IDLE, RECOLOR, GROW, CHECK, OVER.
- Loads are accepted only in IDLE and OVER. Loads at other times are ignored. A load to col or row >= N is stored but never scanned.
- **NEW_GAME (any state, including mid-move):**
  - Latch N, COLOR_NUM, MOVE_LIMIT.
  - Clear mask, then set mask[0]; owned count = 1.
  - CUR = cell 0; MOVES = 0; clear WON and LOST.
  - Go to GROW. No move is counted.
- **Move acceptance (IDLE only):** on COLOR_SEL_SIG the move is refused if COLOR_SELECTED == CUR or COLOR_SELECTED >= COLOR_NUM.
  - A refused move pulses REJECTED and leaves all state unchanged.
  - COLOR_SEL_SIG in any other state is ignored, with no REJECTED pulse.
- **Accepted move:**
  - CUR = COLOR_SELECTED; MOVES increments, saturating at all-ones.
  - Go to RECOLOR.
- **RECOLOR:** scan every active cell in row-major order, one cell per cycle. Owned cells are written with CUR.
- **GROW:** scan every active cell in row-major order, one cell per cycle.
  - An unowned cell joins when its colour == CUR and any in-bounds 4-neighbour is owned.
  - Neighbours are only those with row/col in 0..N-1. There is no wrap from col N-1 to the next row.
  - The mask updates immediately, so later cells in the same pass see the new owners.
  - A changed flag is set on any join.
  - At the end of a pass: if changed, clear the flag and repeat the pass; otherwise go to CHECK.
- **CHECK:**
  - WON = (owned count == N*N).
  - LOST = !WON && MOVE_LIMIT != 0 && MOVES >= MOVE_LIMIT.
  - Pulse MOVE_DONE. Go to OVER if WON or LOST, otherwise IDLE.
- **OVER:** only NEW_GAME and loads have effect.

## Timing
- Reset values: RD_COLOR 0, BUSY 0, MOVE_DONE 0, REJECTED 0, MOVES 0, WON 0, LOST 0.
- Reset state: IDLE, mask clear, CUR 0. RAM contents are undefined after reset.
- RESET mid-move aborts the move immediately; the RAM is not rewritten.
- RD_COLOR = RAM[RD_ADDR] one cycle after RD_ADDR is presented, in all states. Reads during RECOLOR may return either the old or new colour of a cell.
- BUSY is high from the cycle after a NEW_GAME or accepted COLOR_SEL_SIG through the CHECK cycle.
- Move latency, strobe to MOVE_DONE: 1 + N² (RECOLOR) + k·N² (GROW, k >= 1 passes) + 1 cycles.
- MOVE_DONE and REJECTED are registered pulses, high for exactly one cycle.
- WON and LOST change in the same cycle that MOVE_DONE rises.

## Test plan
- **Board setup for tests 1–3:** N=3, COLOR_NUM=4, MOVE_LIMIT=0; load rows 0 1 1 / 2 1 0 / 2 2 2; then NEW_GAME.
  - Required: MOVE_DONE after 1+9+1 cycles, owned count 1, CUR=0, MOVES=0.
- **Move 1:** COLOR_SEL_SIG with colour 1.
  - Required: MOVE_DONE exactly 29 cycles after the strobe; cells (0,0),(0,1),(0,2),(1,1) read back 1; MOVES=1; WON=0.
- **Moves 2 and 3:** colour 2, then colour 0.
  - Required: after colour 2, owned count 8; after colour 0, all nine cells read 0, WON=1, MOVES=3.
  - A further COLOR_SEL_SIG is ignored: no REJECTED, MOVES stays 3.
- **Illegal moves:** colour equal to CUR, and colour 5 with COLOR_NUM=4.
  - Required: REJECTED pulses one cycle for each; BUSY stays 0; MOVES and RAM unchanged.
- **Move limit:** MOVE_LIMIT=1 on the same board; play colour 1.
  - Required: LOST=1 with MOVE_DONE, state OVER; a subsequent NEW_GAME clears LOST and MOVES.
- **Aborts:**
  - Assert NEW_GAME during GROW of a move: MOVES=0 and the fresh initial flood completes.
  - Assert RESET mid-RECOLOR: all outputs return to their reset values asynchronously.
  - N=26 edge test: colour at (0,25) must not join through (1,0).

Source files
------------

// File: rtl/flood_engine.sv
// rtl/flood_engine.sv - Flood-It board state and flood-fill engine
//
// Holds the cell colour RAM and the owned-region mask. Moves recolour the
// owned region, then grow it by repeated row-major passes until stable.
//
// Ports:
//   CLOCK, RESET            engine clock, asynchronous active-high reset
//   SIZE, COLOR_NUM,        board edge, colours in play, move limit;
//   MOVE_LIMIT              latched on NEW_GAME
//   LOAD_EN/ADDR/COLOR      cell load port (honoured in IDLE and OVER only)
//   NEW_GAME                start a game on the loaded board
//   COLOR_SEL_SIG/SELECTED  move strobe and colour
//   RD_ADDR -> RD_COLOR     registered display read port
//   BUSY, MOVE_DONE,        status: processing, completion pulse,
//   REJECTED, MOVES,        refused-move pulse, accepted move count,
//   WON, LOST               game result
module flood_engine #(
    parameter int MAX_SIZE   = 26,
    parameter int COLOR_BITS = 3,
    parameter int ADDR_BITS  = 10,
    parameter int MOVE_BITS  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [4:0]            SIZE,
    input  logic [3:0]            COLOR_NUM,
    input  logic [MOVE_BITS-1:0]  MOVE_LIMIT,
    input  logic                  LOAD_EN,
    input  logic [ADDR_BITS-1:0]  LOAD_ADDR,
    input  logic [COLOR_BITS-1:0] LOAD_COLOR,
    input  logic                  NEW_GAME,
    input  logic                  COLOR_SEL_SIG,
    input  logic [COLOR_BITS-1:0] COLOR_SELECTED,
    input  logic [ADDR_BITS-1:0]  RD_ADDR,
    output logic [COLOR_BITS-1:0] RD_COLOR,
    output logic                  BUSY,
    output logic                  MOVE_DONE,
    output logic                  REJECTED,
    output logic [MOVE_BITS-1:0]  MOVES,
    output logic                  WON,
    output logic                  LOST
);
    localparam int CELLS    = MAX_SIZE * MAX_SIZE;
    localparam int CNT_BITS = ADDR_BITS + 1;
    localparam int CMP_BITS = (COLOR_BITS > 4) ? COLOR_BITS : 4;
    localparam logic [4:0]           MAX_N      = 5'(MAX_SIZE);
    localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(MAX_SIZE);
    localparam logic [ADDR_BITS-1:0] LAST_CELL  = ADDR_BITS'(CELLS - 1);
    localparam logic [ADDR_BITS-1:0] ONE_CELL   = ADDR_BITS'(1);

    typedef enum logic [2:0] {IDLE, RECOLOR, GROW, CHECK, OVER} state_t;

    state_t                state;
    logic [COLOR_BITS-1:0] ram [CELLS];
    logic [CELLS-1:0]      mask;
    logic [COLOR_BITS-1:0] cur;
    logic [CNT_BITS-1:0]   owned_cnt;
    logic [4:0]            row;
    logic [4:0]            col;
    logic [4:0]            n;
    logic [3:0]            color_num;
    logic [MOVE_BITS-1:0]  move_limit;
    logic                  changed;

    logic [ADDR_BITS-1:0]  scan_addr;
    logic [4:0]            row_nxt;
    logic [4:0]            col_nxt;
    logic [4:0]            size_clamped;
    logic                  pass_end;
    logic                  nb_owned;
    logic                  join_cell;
    logic                  load_ok;
    logic                  sel_bad;
    logic                  won_now;
    logic                  lost_now;

    always_comb begin
        scan_addr = ADDR_BITS'(row) * ROW_STRIDE + ADDR_BITS'(col);
        pass_end  = (col == n - 5'd1) && (row == n - 5'd1);
        if (col == n - 5'd1) begin
            col_nxt = 5'd0;
            row_nxt = row + 5'd1;
        end else begin
            col_nxt = col + 5'd1;
            row_nxt = row;
        end

        // Bounds are checked on row/col, never on the flat address, so
        // column N-1 and column 0 of the next row are not neighbours.
        nb_owned = 1'b0;
        if (row != 5'd0 && mask[scan_addr - ROW_STRIDE])
            nb_owned = 1'b1;
        if (row != n - 5'd1 && mask[scan_addr + ROW_STRIDE])
            nb_owned = 1'b1;
        if (col != 5'd0 && mask[scan_addr - ONE_CELL])
            nb_owned = 1'b1;
        if (col != n - 5'd1 && mask[scan_addr + ONE_CELL])
            nb_owned = 1'b1;

        join_cell = (state == GROW) && !mask[scan_addr] &&
                    (ram[scan_addr] == cur) && nb_owned;

        load_ok = LOAD_EN && !RESET && (state == IDLE || state == OVER) &&
                  (LOAD_ADDR <= LAST_CELL);

        sel_bad = (COLOR_SELECTED == cur) ||
                  (CMP_BITS'(COLOR_SELECTED) >= CMP_BITS'(color_num));

        if (SIZE < 5'd2)
            size_clamped = 5'd2;
        else if (SIZE > MAX_N)
            size_clamped = MAX_N;
        else
            size_clamped = SIZE;

        won_now  = (owned_cnt == CNT_BITS'(n) * CNT_BITS'(n));
        lost_now = !won_now && (move_limit != '0) && (MOVES >= move_limit);
    end

    // Cell RAM: loads and recolour writes are mutually exclusive by state.
    always_ff @(posedge CLOCK) begin
        if (load_ok)
            ram[LOAD_ADDR] <= LOAD_COLOR;
        else if (state == RECOLOR && mask[scan_addr])
            ram[scan_addr] <= cur;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            RD_COLOR <= '0;
        else if (RD_ADDR <= LAST_CELL)
            RD_COLOR <= ram[RD_ADDR];
        else
            RD_COLOR <= '0;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            mask       <= '0;
            cur        <= '0;
            owned_cnt  <= '0;
            row        <= 5'd0;
            col        <= 5'd0;
            n          <= 5'd2;
            color_num  <= '0;
            move_limit <= '0;
            changed    <= 1'b0;
            BUSY       <= 1'b0;
            MOVE_DONE  <= 1'b0;
            REJECTED   <= 1'b0;
            MOVES      <= '0;
            WON        <= 1'b0;
            LOST       <= 1'b0;
        end else begin
            MOVE_DONE <= 1'b0;
            REJECTED  <= 1'b0;
            if (NEW_GAME) begin
                n          <= size_clamped;
                color_num  <= COLOR_NUM;
                move_limit <= MOVE_LIMIT;
                mask       <= CELLS'(1);
                owned_cnt  <= CNT_BITS'(1);
                cur        <= ram[0];
                MOVES      <= '0;
                WON        <= 1'b0;
                LOST       <= 1'b0;
                row        <= 5'd0;
                col        <= 5'd0;
                changed    <= 1'b0;
                BUSY       <= 1'b1;
                state      <= GROW;
            end else begin
                case (state)
                    IDLE: begin
                        if (COLOR_SEL_SIG) begin
                            if (sel_bad) begin
                                REJECTED <= 1'b1;
                            end else begin
                                cur <= COLOR_SELECTED;
                                if (MOVES != '1)
                                    MOVES <= MOVES + MOVE_BITS'(1);
                                row   <= 5'd0;
                                col   <= 5'd0;
                                BUSY  <= 1'b1;
                                state <= RECOLOR;
                            end
                        end
                    end
                    RECOLOR: begin
                        if (pass_end) begin
                            row     <= 5'd0;
                            col     <= 5'd0;
                            changed <= 1'b0;
                            state   <= GROW;
                        end else begin
                            row <= row_nxt;
                            col <= col_nxt;
                        end
                    end
                    GROW: begin
                        if (join_cell) begin
                            mask[scan_addr] <= 1'b1;
                            owned_cnt       <= owned_cnt + CNT_BITS'(1);
                            changed         <= 1'b1;
                        end
                        if (pass_end) begin
                            row <= 5'd0;
                            col <= 5'd0;
                            // A join on the last cell also forces another pass.
                            if (changed || join_cell)
                                changed <= 1'b0;
                            else
                                state <= CHECK;
                        end else begin
                            row <= row_nxt;
                            col <= col_nxt;
                        end
                    end
                    CHECK: begin
                        BUSY      <= 1'b0;
                        MOVE_DONE <= 1'b1;
                        WON       <= won_now;
                        LOST      <= lost_now;
                        state     <= (won_now || lost_now) ? OVER : IDLE;
                    end
                    OVER: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flood_engine.sv
// tb/tb_flood_engine.sv - self-checking bench for flood_engine
module tb_flood_engine;
    localparam int MS = 26;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] SIZE = 5'd3;
    logic [3:0] COLOR_NUM = 4'd4;
    logic [7:0] MOVE_LIMIT = 8'd0;
    logic       LOAD_EN = 1'b0;
    logic [9:0] LOAD_ADDR = '0;
    logic [2:0] LOAD_COLOR = '0;
    logic       NEW_GAME = 1'b0;
    logic       COLOR_SEL_SIG = 1'b0;
    logic [2:0] COLOR_SELECTED = '0;
    logic [9:0] RD_ADDR = '0;
    logic [2:0] RD_COLOR;
    logic       BUSY;
    logic       MOVE_DONE;
    logic       REJECTED;
    logic [7:0] MOVES;
    logic       WON;
    logic       LOST;

    flood_engine dut (
        .CLOCK(CLOCK), .RESET(RESET), .SIZE(SIZE), .COLOR_NUM(COLOR_NUM),
        .MOVE_LIMIT(MOVE_LIMIT), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
        .LOAD_COLOR(LOAD_COLOR), .NEW_GAME(NEW_GAME),
        .COLOR_SEL_SIG(COLOR_SEL_SIG), .COLOR_SELECTED(COLOR_SELECTED),
        .RD_ADDR(RD_ADDR), .RD_COLOR(RD_COLOR), .BUSY(BUSY),
        .MOVE_DONE(MOVE_DONE), .REJECTED(REJECTED), .MOVES(MOVES),
        .WON(WON), .LOST(LOST)
    );

    always #5 CLOCK = ~CLOCK;

    int m_board [MS*MS];
    bit m_own   [MS*MS];
    int m_n, m_cnum, m_limit, m_cur, m_moves;
    bit m_won, m_lost;

    bit chk_en = 1'b0;
    bit exp_busy, exp_done, exp_rej, exp_won, exp_lost;
    int exp_moves;
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check("busy", int'(BUSY), int'(exp_busy));
            check("move_done", int'(MOVE_DONE), int'(exp_done));
            check("rejected", int'(REJECTED), int'(exp_rej));
            check("moves", int'(MOVES), exp_moves);
            check("won", int'(WON), int'(exp_won));
            check("lost", int'(LOST), int'(exp_lost));
        end
    end

    function automatic int idx(input int r, input int c);
        return r * MS + c;
    endfunction

    function automatic bit touches_owned(input int r, input int c);
        if (r > 0 && m_own[idx(r-1, c)]) return 1'b1;
        if (r < m_n-1 && m_own[idx(r+1, c)]) return 1'b1;
        if (c > 0 && m_own[idx(r, c-1)]) return 1'b1;
        if (c < m_n-1 && m_own[idx(r, c+1)]) return 1'b1;
        return 1'b0;
    endfunction

    // Row-major growth passes with immediate visibility; returns pass count.
    function automatic int grow_passes();
        int k = 0;
        bit ch;
        do begin
            ch = 1'b0;
            k++;
            for (int r = 0; r < m_n; r++)
                for (int c = 0; c < m_n; c++)
                    if (!m_own[idx(r,c)] && m_board[idx(r,c)] == m_cur &&
                        touches_owned(r, c)) begin
                        m_own[idx(r,c)] = 1'b1;
                        ch = 1'b1;
                    end
        end while (ch);
        return k;
    endfunction

    function automatic int owned_count();
        int cnt = 0;
        for (int i = 0; i < MS*MS; i++) cnt += int'(m_own[i]);
        return cnt;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
        exp_done = 1'b0;
        exp_rej  = 1'b0;
    endtask

    task automatic settle();
        m_won  = (owned_count() == m_n * m_n);
        m_lost = !m_won && m_limit != 0 && m_moves >= m_limit;
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_won  = m_won;
        exp_lost = m_lost;
    endtask

    task automatic finish_op(input int lat);
        for (int j = 1; j < lat; j++) begin
            tick();
            if (j == lat - 1) settle();
        end
        tick();
    endtask

    task automatic new_game(input int size_in, input int cnum, input int limit,
                            output int lat);
        int k;
        SIZE = 5'(size_in);
        COLOR_NUM = 4'(cnum);
        MOVE_LIMIT = 8'(limit);
        NEW_GAME = 1'b1;
        tick();
        NEW_GAME = 1'b0;
        m_n = (size_in < 2) ? 2 : (size_in > MS) ? MS : size_in;
        m_cnum = cnum;
        m_limit = limit;
        foreach (m_own[i]) m_own[i] = 1'b0;
        m_own[0] = 1'b1;
        m_cur = m_board[0];
        m_moves = 0;
        m_won = 1'b0;
        m_lost = 1'b0;
        exp_busy = 1'b1;
        exp_moves = 0;
        exp_won = 1'b0;
        exp_lost = 1'b0;
        k = grow_passes();
        lat = 1 + k * m_n * m_n + 1;
        finish_op(lat);
    endtask

    // stop_at != 0 returns before that edge, leaving the engine mid-move.
    task automatic run_move(input int c, input int stop_at, input bit junk,
                            output int lat);
        int k;
        lat = 0;
        COLOR_SELECTED = 3'(c);
        COLOR_SEL_SIG = 1'b1;
        tick();
        COLOR_SEL_SIG = 1'b0;
        if (m_won || m_lost) return;
        if (c == m_cur || c >= m_cnum) begin
            exp_rej = 1'b1;
            tick();
            return;
        end
        m_cur = c;
        if (m_moves < 255) m_moves++;
        exp_moves = m_moves;
        exp_busy = 1'b1;
        for (int i = 0; i < MS*MS; i++)
            if (m_own[i]) m_board[i] = c;
        k = grow_passes();
        lat = 2 + m_n * m_n * (k + 1);
        for (int j = 1; j < lat; j++) begin
            if (stop_at != 0 && j == stop_at) return;
            if (junk && j == 3) begin
                LOAD_EN = 1'b1;
                LOAD_ADDR = '0;
                LOAD_COLOR = 3'd7;
                COLOR_SEL_SIG = 1'b1;
                COLOR_SELECTED = (m_cur == 0) ? 3'd1 : 3'd0;
            end
            tick();
            LOAD_EN = 1'b0;
            COLOR_SEL_SIG = 1'b0;
            if (j == lat - 1) settle();
        end
        tick();
    endtask

    task automatic load_board(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                LOAD_EN = 1'b1;
                LOAD_ADDR = 10'(idx(r, c));
                LOAD_COLOR = 3'(m_board[idx(r, c)]);
                tick();
            end
        LOAD_EN = 1'b0;
    endtask

    task automatic rd_cell(input int r, input int c, output int v);
        RD_ADDR = 10'(idx(r, c));
        tick();
        v = int'(RD_COLOR);
    endtask

    task automatic check_board(input string name);
        int v;
        for (int r = 0; r < m_n; r++)
            for (int c = 0; c < m_n; c++) begin
                rd_cell(r, c, v);
                check(name, v, m_board[idx(r, c)]);
            end
    endtask

    task automatic set_base();
        int base [9] = '{0, 1, 1, 2, 1, 0, 2, 2, 2};
        for (int i = 0; i < 9; i++) m_board[idx(i / 3, i % 3)] = base[i];
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, v, nn, cnum, limit, size_in;
        exp_busy = 0; exp_done = 0; exp_rej = 0; exp_won = 0; exp_lost = 0;
        exp_moves = 0;
        foreach (m_board[i]) m_board[i] = 0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(MOVE_DONE), 0);
        check("rst_rej", int'(REJECTED), 0);
        check("rst_moves", int'(MOVES), 0);
        check("rst_won", int'(WON), 0);
        check("rst_lost", int'(LOST), 0);
        check("rst_rd", int'(RD_COLOR), 0);
        RESET = 1'b0;
        chk_en = 1'b1;

        set_base();
        load_board(3);
        new_game(3, 4, 0, lat);
        check("init_latency", lat, 11);
        check("init_owned", owned_count(), 1);

        run_move(1, 0, 0, lat);
        check("move1_latency", lat, 29);
        rd_cell(0, 0, v); check("m1_cell00", v, 1);
        rd_cell(0, 1, v); check("m1_cell01", v, 1);
        rd_cell(0, 2, v); check("m1_cell02", v, 1);
        rd_cell(1, 1, v); check("m1_cell11", v, 1);
        check_board("m1_board");

        run_move(1, 0, 0, lat);
        run_move(5, 0, 0, lat);
        check_board("rej_board");

        run_move(2, 0, 0, lat);
        check("m2_owned", owned_count(), 8);
        run_move(0, 0, 0, lat);
        check("m3_won_model", int'(m_won), 1);
        check("m3_moves_model", m_moves, 3);
        for (int i = 0; i < 9; i++) begin
            rd_cell(i / 3, i % 3, v);
            check("m3_cell", v, 0);
        end
        run_move(3, 0, 0, lat);

        set_base();
        load_board(3);
        new_game(3, 4, 1, lat);
        run_move(1, 0, 0, lat);
        check("limit_lost_model", int'(m_lost), 1);
        check("limit_lost_out", int'(LOST), 1);
        run_move(2, 0, 0, lat);
        new_game(3, 4, 0, lat);

        set_base();
        load_board(3);
        new_game(3, 4, 0, lat);
        run_move(1, 13, 0, lat);
        new_game(3, 4, 0, lat);
        check_board("abort_board");

        run_move(2, 4, 0, lat);
        chk_en = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check("arst_busy", int'(BUSY), 0);
        check("arst_done", int'(MOVE_DONE), 0);
        check("arst_rej", int'(REJECTED), 0);
        check("arst_moves", int'(MOVES), 0);
        check("arst_won", int'(WON), 0);
        check("arst_lost", int'(LOST), 0);
        check("arst_rd", int'(RD_COLOR), 0);
        tick();
        tick();
        RESET = 1'b0;
        exp_busy = 0; exp_moves = 0; exp_won = 0; exp_lost = 0;
        m_won = 0; m_lost = 0;
        chk_en = 1'b1;

        foreach (m_board[i]) m_board[i] = 2;
        m_board[idx(0, 0)] = 0;
        m_board[idx(1, 0)] = 0;
        m_board[idx(0, 25)] = 0;
        load_board(26);
        new_game(26, 4, 0, lat);
        check("edge_latency", lat, 1354);
        check("edge_owned", owned_count(), 2);
        run_move(1, 0, 0, lat);
        rd_cell(0, 25, v); check("edge_cell_0_25", v, 0);
        rd_cell(1, 0, v);  check("edge_cell_1_0", v, 1);
        check_board("edge_board");

        for (int g = 0; g < 6; g++) begin
            size_in = (g == 0) ? 1 : int'($urandom_range(2, 6));
            nn = (size_in < 2) ? 2 : size_in;
            cnum = int'($urandom_range(2, 8));
            limit = int'($urandom_range(0, 5));
            for (int r = 0; r < nn; r++)
                for (int c = 0; c < nn; c++)
                    m_board[idx(r, c)] = int'($urandom_range(0, cnum - 1));
            load_board(nn);
            new_game(size_in, cnum, limit, lat);
            check_board("rand_init_board");
            for (int mv = 0; mv < 12; mv++) begin
                if (m_won || m_lost) begin
                    run_move(int'($urandom_range(0, 7)), 0, 0, lat);
                    break;
                end
                run_move(int'($urandom_range(0, 7)), 0, mv == 0, lat);
                check_board("rand_board");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
